// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: stream bundle for the pipelined adder/subtractor.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf
//   master : the producer/consumer environment around the block
//   slave  : the arithmetic block itself
interface pipelined_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor whose carry chain is cut into
// STAGES registered segments of WIDTH/STAGES bits each.
//   sub=0 : {cout,sum} = a + b + cin
//   sub=1 : {cout,sum} = a + ~b + ~cin  (a - b - cin, cout=1 means no borrow)
//   ovf   : signed overflow (carry into MSB xor carry out of MSB)
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : pipelined_addsub_if.slave stream bundle (operands in, result out)
// One result per cycle, latency STAGES cycles; a stalled output freezes the
// whole pipeline and deasserts in_ready.
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                reset,
    pipelined_addsub_if.slave   bus
);
    localparam int SEG = WIDTH / STAGES;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [SEG-1:0]   seg_t;
    typedef logic [SEG+1:0]   segres_t;   // {ovf, cout, sum}

    // One segment of the carry chain. Overflow is only meaningful for the
    // segment holding the MSB.
    function automatic segres_t seg_add(input seg_t x, input seg_t y, input logic c);
        logic [SEG:0] t;
        logic         c_msb;
        t     = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
        c_msb = x[SEG-1] ^ y[SEG-1] ^ t[SEG-1];
        return {t[SEG] ^ c_msb, t};
    endfunction

    // The accumulator word rotates right by one segment per stage: the
    // consumed operand-A segment leaves at the bottom and its sum segment
    // enters at the top. After STAGES rotations every sum segment sits at its
    // natural bit position, which realises both the input skew and the
    // output de-skew in a single register per stage.
    function automatic word_t rotate_in(input word_t acc, input seg_t s);
        return (acc >> SEG) | (WIDTH'(s) << (WIDTH - SEG));
    endfunction

    logic    vld_q [STAGES];
    word_t   acc_q [STAGES];
    word_t   b_q   [STAGES];
    logic    c_q   [STAGES];
    logic    ovf_q;

    logic    vld_in [STAGES];
    word_t   acc_in [STAGES];
    word_t   b_in   [STAGES];
    logic    c_in   [STAGES];
    segres_t res    [STAGES];
    word_t   acc_d  [STAGES];
    word_t   b_d    [STAGES];
    logic    c_d    [STAGES];
    logic    ovf_d;
    logic    stall;

    assign stall         = vld_q[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = acc_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.ovf       = ovf_q;

    always_comb begin
        // Subtraction folds into addition by inverting B and the borrow-in.
        vld_in[0] = bus.in_valid & ~stall;
        acc_in[0] = bus.a;
        b_in[0]   = bus.sub ? ~bus.b : bus.b;
        c_in[0]   = bus.sub ? ~bus.cin : bus.cin;
        for (int s = 1; s < STAGES; s++) begin
            vld_in[s] = vld_q[s-1];
            acc_in[s] = acc_q[s-1];
            b_in[s]   = b_q[s-1];
            c_in[s]   = c_q[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            res[s]   = seg_add(acc_in[s][SEG-1:0], b_in[s][SEG-1:0], c_in[s]);
            acc_d[s] = rotate_in(acc_in[s], res[s][SEG-1:0]);
            b_d[s]   = b_in[s] >> SEG;
            c_d[s]   = res[s][SEG];
        end
        ovf_d = res[STAGES-1][SEG+1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s] <= 1'b0;
                acc_q[s] <= '0;
                b_q[s]   <= '0;
                c_q[s]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s] <= vld_in[s];
                acc_q[s] <= acc_d[s];
                b_q[s]   <= b_d[s];
                c_q[s]   <= c_d[s];
            end
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for pipelined_addsub.
// Three instances: 16/4 (main tests), 4/1 and 8/8 (parameter sweep).
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_addsub_if #(.WIDTH(16)) bm ();
    pipelined_addsub_if #(.WIDTH(4))  b4 ();
    pipelined_addsub_if #(.WIDTH(8))  b8 ();

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_main (.clk(clk), .reset(reset), .bus(bm));
    pipelined_addsub #(.WIDTH(4),  .STAGES(1)) u_w4   (.clk(clk), .reset(reset), .bus(b4));
    pipelined_addsub #(.WIDTH(8),  .STAGES(8)) u_w8   (.clk(clk), .reset(reset), .bus(b8));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t qm[$];
    exp_t q4[$];
    exp_t q8[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural reference: {ovf, cout, sum}
    function automatic logic [17:0] model(input int w, input int a, input int b,
                                          input bit ci, input bit su);
        int mask, lo, bb, cc, t, cm, co;
        logic [17:0] r;
        mask = (1 << w) - 1;
        lo   = mask >> 1;
        bb   = su ? (~b & mask) : (b & mask);
        cc   = (su ? !ci : ci) ? 1 : 0;
        t    = (a & mask) + bb + cc;
        co   = (t >> w) & 1;
        cm   = (((a & lo) + (bb & lo) + cc) >> (w - 1)) & 1;
        r         = '0;
        r[15:0]   = 16'(t & mask);
        r[16]     = co[0];
        r[17]     = co[0] ^ cm[0];
        return r;
    endfunction

    // ---------------- main monitor ----------------
    bit          chk_rdy = 0;
    int          pop_cnt = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_sum;
    logic        prev_cout, prev_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (prev_stall && reset) begin
            chk("hold_valid", 32'(bm.out_valid), 32'd1);
            chk("hold_sum",   32'(bm.sum),  32'(prev_sum));
            chk("hold_cout",  32'(bm.cout), 32'(prev_cout));
            chk("hold_ovf",   32'(bm.ovf),  32'(prev_ovf));
        end
        if (chk_rdy) chk("in_ready", 32'(bm.in_ready), 32'(bm.out_ready));
        prev_stall = reset && bm.out_valid && !bm.out_ready;
        prev_sum   = bm.sum;
        prev_cout  = bm.cout;
        prev_ovf   = bm.ovf;
        if (reset && bm.out_valid && bm.out_ready) begin
            if (qm.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum 0x%0h, expected no output", bm.sum);
            end else begin
                e = qm.pop_front();
                chk("sum",  32'(bm.sum),  32'(e.sum));
                chk("cout", 32'(bm.cout), 32'(e.cout));
                chk("ovf",  32'(bm.ovf),  32'(e.ovf));
                if (e.lat) chk("latency", 32'(cyc - e.cyc + 1), 32'd4);
                pop_cnt++;
                if (pop_cnt == 1) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    // ---------------- sweep monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (reset && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w4_unexpected: got sum 0x%0h, expected no output", b4.sum);
            end else begin
                e = q4.pop_front();
                chk("w4_sum",  32'(b4.sum),  32'(e.sum[3:0]));
                chk("w4_cout", 32'(b4.cout), 32'(e.cout));
                chk("w4_ovf",  32'(b4.ovf),  32'(e.ovf));
                chk("w4_latency", 32'(cyc - e.cyc + 1), 32'd1);
            end
        end
        if (reset && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_unexpected: got sum 0x%0h, expected no output", b8.sum);
            end else begin
                e = q8.pop_front();
                chk("w8_sum",  32'(b8.sum),  32'(e.sum[7:0]));
                chk("w8_cout", 32'(b8.cout), 32'(e.cout));
                chk("w8_ovf",  32'(b8.ovf),  32'(e.ovf));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic su, input logic [15:0] es, input logic ec,
                          input logic eo, input bit lat);
        int w = 0;
        bm.in_valid = 1'b1;
        bm.a = a;
        bm.b = b;
        bm.cin = ci;
        bm.sub = su;
        do begin
            @(negedge clk);
            w++;
        end while (!bm.in_ready && w < 50);
        if (!bm.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", w);
            @(posedge clk);
        end else begin
            @(posedge clk);
            #1;
            qm.push_back('{es, ec, eo, cyc, lat});
        end
        bm.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [3:0] es, input logic ec, input logic eo);
        b4.in_valid = 1'b1;
        b4.a = a;
        b4.b = b;
        b4.cin = ci;
        b4.sub = 1'b0;
        @(negedge clk);
        chk("w4_in_ready", 32'(b4.in_ready), 32'd1);
        @(posedge clk);
        #1;
        q4.push_back('{16'(es), ec, eo, cyc, 1'b1});
        b4.in_valid = 1'b0;
    endtask

    task automatic send8(input int a, input int b, input bit ci, input bit su);
        logic [17:0] r;
        r = model(8, a, b, ci, su);
        b8.in_valid = 1'b1;
        b8.a = 8'(a);
        b8.b = 8'(b);
        b8.cin = ci;
        b8.sub = su;
        @(negedge clk);
        @(posedge clk);
        #1;
        q8.push_back('{r[15:0], r[16], r[17], cyc, 1'b0});
        b8.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int w = 0;
        while ((qm.size() + q4.size() + q8.size()) > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk(nm, 32'(qm.size() + q4.size() + q8.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        bm.in_valid = 0; bm.a = 0; bm.b = 0; bm.cin = 0; bm.sub = 0; bm.out_ready = 1;
        b4.in_valid = 0; b4.a = 0; b4.b = 0; b4.cin = 0; b4.sub = 0; b4.out_ready = 1;
        b8.in_valid = 0; b8.a = 0; b8.b = 0; b8.cin = 0; b8.sub = 0; b8.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bm.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bm.in_ready),  32'd1);
        chk("rst_sum",       32'(bm.sum),       32'd0);
        chk("rst_cout_ovf",  32'({bm.cout, bm.ovf}), 32'd0);
        reset = 1'b1;

        // carry crossing segment boundaries
        send_m(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 1);
        drain("drain_t1");

        // add/sub boundaries, streamed back to back
        send_m(16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0, 1);
        send_m(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1);
        send_m(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 1);
        send_m(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 1);
        drain("drain_t23");

        // back-pressure: 3-cycle stall once results are flowing
        pop_cnt = 0;
        chk_rdy = 1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_m(16'(i), 16'(i * 3), 0, 0, 16'(i * 4), 0, 0, 0);
            end
            begin
                int w = 0;
                while (pop_cnt < 2 && w < 100) begin
                    @(posedge clk);
                    w++;
                end
                @(posedge clk);
                #1;
                bm.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bm.out_ready = 1'b1;
            end
        join
        drain("drain_t4");
        chk_rdy = 0;
        chk("t4_count", 32'(pop_cnt), 32'd8);
        chk("t4_throughput", 32'(last_pop - first_pop), 32'd10);

        // asynchronous reset with entries in flight
        send_m(16'h0101, 16'h0101, 0, 0, 16'h0202, 0, 0, 0);
        send_m(16'h0202, 16'h0202, 0, 0, 16'h0404, 0, 0, 0);
        send_m(16'h0303, 16'h0303, 0, 0, 16'h0606, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(bm.out_valid), 32'd1);
        reset = 1'b0;
        #2;
        chk("async_out_valid", 32'(bm.out_valid), 32'd0);
        chk("async_in_ready",  32'(bm.in_ready),  32'd1);
        chk("async_sum",       32'(bm.sum),       32'd0);
        chk("async_cout_ovf",  32'({bm.cout, bm.ovf}), 32'd0);
        qm.delete();
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_idle", 32'(bm.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send_m(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0, 1);
        drain("drain_t5");

        // WIDTH=4, STAGES=1: hand-computed 4-bit add vectors
        send4(4'h0, 4'h0, 0, 4'h0, 0, 0);
        send4(4'h3, 4'h4, 0, 4'h7, 0, 0);
        send4(4'h7, 4'h1, 0, 4'h8, 0, 1);
        send4(4'hF, 4'h1, 0, 4'h0, 1, 0);
        send4(4'h8, 4'h8, 0, 4'h0, 1, 1);
        send4(4'h5, 4'hA, 1, 4'h0, 1, 0);
        send4(4'h9, 4'h6, 0, 4'hF, 0, 0);
        send4(4'hC, 4'hC, 1, 4'h9, 1, 0);
        send4(4'h2, 4'h3, 1, 4'h6, 0, 0);
        send4(4'h8, 4'hF, 0, 4'h7, 1, 1);
        drain("drain_w4");

        // WIDTH=8, STAGES=8: random add/sub against the reference model
        for (int i = 0; i < 200; i++)
            send8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        drain("drain_w8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
